cp0_exc_ctrl: RTL and testbench
===============================

// Module: cp0_exc_ctrl
// PURPOSE
//  Consumer of the encoded excepttype produced in MEM: holds the CP0 registers
//  BadVAddr, Count, Compare, Status, Cause and EPC, and commits exceptions.
//  Supplies Status/Cause back to the exception encoder, and flush/newpc to the
//  PC and pipeline control. Supports mtc0/mfc0 access and the Count/Compare timer.
// PARAMETERS
//  EXC_VECTOR  32'hBFC00380  exception entry address, used for every type except eret
//  CNT_DIV     1             Count increments once per 2**CNT_DIV clocks
// PORTS
//  clk             in   1   clock
//  resetn          in   1   asynchronous active-low reset
//  excepttype_i    in   32  0=none; 01 Int, 04 AdEL, 05 AdES, 08 Sys, 09 Bp, 0a RI, 0c Ov, 0e eret
//  pc_i            in   32  PC of the MEM-stage instruction
//  in_delayslot_i  in   1   MEM-stage instruction is in a branch delay slot
//  bad_addr_i      in   32  faulting address for AdEL/AdES
//  int_i           in   6   hardware interrupt lines, level-sensitive
//  we_i            in   1   mtc0 write enable
//  waddr_i         in   5   mtc0 register number
//  wdata_i         in   32  mtc0 data
//  raddr_i         in   5   mfc0 register number
//  rdata_o         out  32  mfc0 data; combinational from current registers; 0 for unimplemented registers
//  status_o        out  32  Status register
//  cause_o         out  32  Cause register
//  epc_o           out  32  EPC register
//  flush_o         out  1   pipeline flush; combinational, high when excepttype_i != 0
//  newpc_o         out  32  redirect target: EPC for eret (0e), EXC_VECTOR otherwise
//  timer_int_o     out  1   sticky timer interrupt, mirrors Cause.IP7
// BEHAVIOUR
//  Reset values (async, while resetn=0):
//   - Status = 32'h0040_0000 (BEV=1, all other bits 0)
//   - Cause, EPC, BadVAddr, Count, Compare = 0; Count prescaler = 0
//   - timer_int_o = 0
//  Writable bits:
//   - Status: IM[15:8], EXL[1], IE[0]; BEV always reads 1
//   - Cause: IP[9:8] only
//   - Count and Compare: full 32 bits
//   - BadVAddr and EPC: full 32 bits
//  Every clock:
//   - Cause.IP[15:10] <= {timer_int | int_i[5], int_i[4:0]}
//   - Prescaler increments; when it wraps, Count increments mod 2^32 (32'hFFFFFFFF -> 0)
//   - When Count == Compare and Compare != 0, timer_int is set; it stays set until Compare is written
//  mtc0:
//   - Write to Count reloads Count and clears the prescaler
//   - Write to Compare clears timer_int
//   - Write to Cause updates only IP[9:8]
//  Exception commit, excepttype_i not in {0, 0e}, applied at the clock edge:
//   - If Status.EXL=0: EPC <= in_delayslot_i ? pc_i-4 : pc_i; Cause.BD <= in_delayslot_i
//   - If Status.EXL=1: EPC and BD are unchanged
//   - Status.EXL <= 1
//   - Cause.ExcCode[6:2] <= 0,4,5,8,9,10,12 for 01,04,05,08,09,0a,0c respectively
//   - BadVAddr <= bad_addr_i for 04/05 only
//  eret (0e): Status.EXL <= 0; newpc_o = EPC as held before that edge
//  Unrecognised nonzero excepttype_i: flush_o=1, newpc_o=EXC_VECTOR, registers unchanged
//  Latency: flush_o/newpc_o are combinational in the same cycle; register updates are visible the next cycle
//  Simultaneous events:
//   - An exception or eret in the same cycle as we_i: the exception wins and the mtc0 write is dropped
//     (the instruction is being flushed)
//   - The Count increment and timer compare still occur
//   - Writing Count to the Compare value does not set timer_int that cycle; the next match sets it
//  Reset asserted mid-operation: all registers return to reset values immediately; flush_o follows excepttype_i
// STRUCTURE
//  Shared package/header cp0_defs:
//   - register numbers: BADVADDR=8, COUNT=9, COMPARE=11, STATUS=12, CAUSE=13, EPC=14
//   - excepttype codes and ExcCode values
//   - Status/Cause bit positions
//  Sub-module cp0_timer: Count, prescaler, Compare and the sticky timer_int
// TESTING
//  1. Reset, then read registers 12 and 13 -> 32'h00400000 and 0; flush_o=0
//  2. excepttype=0c, pc=32'h80001000, delayslot=1 -> flush_o=1, newpc=BFC00380;
//     next cycle EPC=32'h80000FFC, Cause.BD=1, ExcCode=12, EXL=1
//  3. Exception with EXL=1 at pc=32'h80002000 -> EPC unchanged; then eret -> newpc=old EPC, EXL=0 next cycle
//  4. excepttype=04, bad_addr=32'h00000003 -> BadVAddr=3, ExcCode=4; concurrent mtc0 to Status is dropped
//  5. Write Compare=10, Count=0, CNT_DIV=1 -> timer_int_o rises about 20 clocks later, Cause.IP7=1;
//     write Compare -> timer_int_o clears
//  6. Count=32'hFFFFFFFF -> wraps to 0; int_i=6'b000001 -> Cause bit 10 set the next cycle

Source files
------------

// File: rtl/cp0_defs.sv
// CP0 shared definitions: register numbers, excepttype codes, ExcCode values,
// Status/Cause field positions and the excepttype decoder.
package cp0_defs;

    // mtc0/mfc0 register numbers
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    // Encoded excepttype values arriving from MEM
    localparam logic [31:0] EXC_NONE = 32'h00;
    localparam logic [31:0] EXC_INT  = 32'h01;
    localparam logic [31:0] EXC_ADEL = 32'h04;
    localparam logic [31:0] EXC_ADES = 32'h05;
    localparam logic [31:0] EXC_SYS  = 32'h08;
    localparam logic [31:0] EXC_BP   = 32'h09;
    localparam logic [31:0] EXC_RI   = 32'h0a;
    localparam logic [31:0] EXC_OV   = 32'h0c;
    localparam logic [31:0] EXC_ERET = 32'h0e;

    // Cause.ExcCode values
    localparam logic [4:0] CODE_INT  = 5'd0;
    localparam logic [4:0] CODE_ADEL = 5'd4;
    localparam logic [4:0] CODE_ADES = 5'd5;
    localparam logic [4:0] CODE_SYS  = 5'd8;
    localparam logic [4:0] CODE_BP   = 5'd9;
    localparam logic [4:0] CODE_RI   = 5'd10;
    localparam logic [4:0] CODE_OV   = 5'd12;

    // Status field positions
    localparam int unsigned ST_IE    = 0;
    localparam int unsigned ST_EXL   = 1;
    localparam int unsigned ST_IM_LO = 8;
    localparam int unsigned ST_IM_HI = 15;
    localparam int unsigned ST_BEV   = 22;

    // Cause field positions
    localparam int unsigned CA_EXC_LO  = 2;
    localparam int unsigned CA_EXC_HI  = 6;
    localparam int unsigned CA_IPSW_LO = 8;
    localparam int unsigned CA_IPSW_HI = 9;
    localparam int unsigned CA_IPHW_LO = 10;
    localparam int unsigned CA_IPHW_HI = 15;
    localparam int unsigned CA_BD      = 31;

    typedef struct packed {
        logic       valid;    // recognised exception that commits state
        logic       badaddr;  // address error: BadVAddr is loaded
        logic [4:0] code;     // ExcCode to record
    } exc_dec_t;

    // Map an excepttype to its commit action; eret and unknown codes are not "valid"
    function automatic exc_dec_t exc_decode(input logic [31:0] t);
        exc_dec_t d;
        d = '0;
        d.valid = 1'b1;
        case (t)
            EXC_INT:  d.code = CODE_INT;
            EXC_ADEL: begin d.code = CODE_ADEL; d.badaddr = 1'b1; end
            EXC_ADES: begin d.code = CODE_ADES; d.badaddr = 1'b1; end
            EXC_SYS:  d.code = CODE_SYS;
            EXC_BP:   d.code = CODE_BP;
            EXC_RI:   d.code = CODE_RI;
            EXC_OV:   d.code = CODE_OV;
            default:  d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: prescaled Count, Compare and a sticky match interrupt.
module cp0_timer
    import cp0_defs::*;
#(
    parameter int unsigned CNT_DIV = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic        tick;
    logic [31:0] count_q, count_d, compare_q, compare_d;
    logic        tint_q, tint_d;

    if (CNT_DIV == 0) begin : g_nodiv
        assign tick = 1'b1;
    end else begin : g_div
        logic [CNT_DIV-1:0] presc_q, presc_d;
        // Prescaler restarts whenever Count is reloaded so the first step is a full period
        always_comb presc_d = count_we_i ? '0 : presc_q + 1'b1;
        // Prescaler register
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) presc_q <= '0;
            else         presc_q <= presc_d;
        end
        assign tick = &presc_q;
    end

    // Next-state: the match uses the registered Count, so a Count write landing on
    // Compare only raises the interrupt on the following edge; a Compare write clears it
    always_comb begin
        count_d   = count_q;
        compare_d = compare_q;
        tint_d    = tint_q | ((count_q == compare_q) && (compare_q != '0));
        if (count_we_i)      count_d = wdata_i;
        else if (tick)       count_d = count_q + 32'd1;
        if (compare_we_i) begin
            compare_d = wdata_i;
            tint_d    = 1'b0;
        end
    end

    // Timer state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q   <= '0;
            compare_q <= '0;
            tint_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            tint_q    <= tint_d;
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = tint_q;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller: holds Status/Cause/EPC/BadVAddr, commits exceptions
// from MEM, serves mtc0/mfc0 and drives flush/redirect.
module cp0_exc_ctrl
    import cp0_defs::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter int unsigned CNT_DIV    = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    input  logic [5:0]  int_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        flush_o,
    output logic [31:0] newpc_o,
    output logic        timer_int_o
);

    exc_dec_t    dec;
    logic        is_eret, mtc0_we;
    logic [31:0] count, compare;
    logic        timer_int;

    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d, ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  iphw_q, iphw_d;
    logic [1:0]  ipsw_q, ipsw_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] epc_q, epc_d, badv_q, badv_d;

    assign dec     = exc_decode(excepttype_i);
    assign is_eret = (excepttype_i == EXC_ERET);
    assign flush_o = (excepttype_i != EXC_NONE);
    assign newpc_o = is_eret ? epc_q : EXC_VECTOR;
    // A flushed instruction must not retire its mtc0
    assign mtc0_we = we_i & ~flush_o;

    cp0_timer #(.CNT_DIV(CNT_DIV)) u_timer (
        .clk          (clk),
        .resetn       (resetn),
        .count_we_i   (mtc0_we && (waddr_i == CP0_COUNT)),
        .compare_we_i (mtc0_we && (waddr_i == CP0_COMPARE)),
        .wdata_i      (wdata_i),
        .count_o      (count),
        .compare_o    (compare),
        .timer_int_o  (timer_int)
    );
    assign timer_int_o = timer_int;

    // Next-state: exception commit beats eret beats mtc0; hardware IP always samples
    always_comb begin
        im_d   = im_q;
        exl_d  = exl_q;
        ie_d   = ie_q;
        bd_d   = bd_q;
        ipsw_d = ipsw_q;
        code_d = code_q;
        epc_d  = epc_q;
        badv_d = badv_q;
        iphw_d = {timer_int | int_i[5], int_i[4:0]};
        if (dec.valid) begin
            // Nested exception keeps the original return point
            if (!exl_q) begin
                epc_d = in_delayslot_i ? pc_i - 32'd4 : pc_i;
                bd_d  = in_delayslot_i;
            end
            exl_d  = 1'b1;
            code_d = dec.code;
            if (dec.badaddr) badv_d = bad_addr_i;
        end else if (is_eret) begin
            exl_d = 1'b0;
        end else if (mtc0_we) begin
            case (waddr_i)
                CP0_STATUS: begin
                    im_d  = wdata_i[ST_IM_HI:ST_IM_LO];
                    exl_d = wdata_i[ST_EXL];
                    ie_d  = wdata_i[ST_IE];
                end
                CP0_CAUSE:    ipsw_d = wdata_i[CA_IPSW_HI:CA_IPSW_LO];
                CP0_EPC:      epc_d  = wdata_i;
                CP0_BADVADDR: badv_d = wdata_i;
                default: ;
            endcase
        end
    end

    // Status/Cause/EPC/BadVAddr registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            im_q   <= '0;
            exl_q  <= 1'b0;
            ie_q   <= 1'b0;
            bd_q   <= 1'b0;
            iphw_q <= '0;
            ipsw_q <= '0;
            code_q <= '0;
            epc_q  <= '0;
            badv_q <= '0;
        end else begin
            im_q   <= im_d;
            exl_q  <= exl_d;
            ie_q   <= ie_d;
            bd_q   <= bd_d;
            iphw_q <= iphw_d;
            ipsw_q <= ipsw_d;
            code_q <= code_d;
            epc_q  <= epc_d;
            badv_q <= badv_d;
        end
    end

    // Assemble architectural Status/Cause views; BEV is hardwired to 1
    always_comb begin
        status_o = '0;
        status_o[ST_BEV]            = 1'b1;
        status_o[ST_IM_HI:ST_IM_LO] = im_q;
        status_o[ST_EXL]            = exl_q;
        status_o[ST_IE]             = ie_q;
        cause_o = '0;
        cause_o[CA_BD]                   = bd_q;
        cause_o[CA_IPHW_HI:CA_IPHW_LO]   = iphw_q;
        cause_o[CA_IPSW_HI:CA_IPSW_LO]   = ipsw_q;
        cause_o[CA_EXC_HI:CA_EXC_LO]     = code_q;
    end
    assign epc_o = epc_q;

    // mfc0 read mux; unimplemented registers read as zero
    always_comb begin
        rdata_o = '0;
        case (raddr_i)
            CP0_BADVADDR: rdata_o = badv_q;
            CP0_COUNT:    rdata_o = count;
            CP0_COMPARE:  rdata_o = compare;
            CP0_STATUS:   rdata_o = status_o;
            CP0_CAUSE:    rdata_o = cause_o;
            CP0_EPC:      rdata_o = epc_q;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl with hand-computed expectations.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] excepttype, pc, bad_addr, wdata, rdata, status, cause, epc, newpc;
    logic        ds, we, flush, tint;
    logic [5:0]  int_l;
    logic [4:0]  waddr, raddr;

    int n_assert = 0;
    int n_fail   = 0;

    cp0_exc_ctrl dut (
        .clk(clk), .resetn(resetn), .excepttype_i(excepttype), .pc_i(pc),
        .in_delayslot_i(ds), .bad_addr_i(bad_addr), .int_i(int_l), .we_i(we),
        .waddr_i(waddr), .wdata_i(wdata), .raddr_i(raddr), .rdata_o(rdata),
        .status_o(status), .cause_o(cause), .epc_o(epc), .flush_o(flush),
        .newpc_o(newpc), .timer_int_o(tint)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs and samples live at +1
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
        raddr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        cyc();
        we = 1'b0;
    endtask

    task automatic exc(input logic [31:0] t, input logic [31:0] p, input logic d,
                       input logic [31:0] exp_newpc, input string tag);
        excepttype = t; pc = p; ds = d;
        #1;
        chk({tag, "_flush"}, 32'(flush), 32'd1);
        chk({tag, "_newpc"}, newpc, exp_newpc);
        cyc();
        excepttype = '0; ds = 1'b0;
    endtask

    initial begin
        int n;
        resetn = 1'b0; excepttype = '0; pc = '0; ds = 1'b0; bad_addr = '0;
        int_l = '0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
        repeat (3) cyc();

        // 1. reset state
        rd(5'd12, 32'h00400000, "rst_status");
        rd(5'd13, 32'h0, "rst_cause");
        rd(5'd9, 32'h0, "rst_count");
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_tint", 32'(tint), 32'd0);
        resetn = 1'b1;
        cyc();

        // 2. Ov in delay slot
        exc(32'h0c, 32'h80001000, 1'b1, 32'hBFC00380, "ov");
        chk("ov_epc", epc, 32'h80000FFC);
        chk("ov_cause", cause, 32'h80000030);
        chk("ov_status", status, 32'h00400002);

        // 3. nested Sys keeps EPC/BD, then eret returns to it
        exc(32'h08, 32'h80002000, 1'b0, 32'hBFC00380, "sys");
        chk("sys_epc", epc, 32'h80000FFC);
        chk("sys_cause", cause, 32'h80000020);
        exc(32'h0e, 32'h0, 1'b0, 32'h80000FFC, "eret1");
        chk("eret1_status", status, 32'h00400000);

        // 4. AdEL with a concurrent mtc0 Status that must be dropped
        bad_addr = 32'h00000003; we = 1'b1; waddr = 5'd12; wdata = 32'hFFFFFFFF;
        exc(32'h04, 32'h80003000, 1'b0, 32'hBFC00380, "adel");
        we = 1'b0;
        chk("adel_status", status, 32'h00400002);
        rd(5'd8, 32'h00000003, "adel_badv");
        chk("adel_cause", cause, 32'h00000010);
        chk("adel_epc", epc, 32'h80003000);
        exc(32'h0e, 32'h0, 1'b0, 32'h80003000, "eret2");
        chk("eret2_status", status, 32'h00400000);

        // mtc0 write masks on Status and Cause
        mtc0(5'd12, 32'hFFFFFFFF);
        chk("mtc0_status", status, 32'h0040FF03);
        mtc0(5'd12, 32'h0);
        chk("mtc0_status0", status, 32'h00400000);
        mtc0(5'd13, 32'hFFFFFFFF);
        chk("mtc0_cause", cause, 32'h00000310);

        // unrecognised code: flush to vector, no state change
        exc(32'h33, 32'h80005000, 1'b1, 32'hBFC00380, "unk");
        chk("unk_status", status, 32'h00400000);
        chk("unk_cause", cause, 32'h00000310);
        chk("unk_epc", epc, 32'h80003000);

        // Int records ExcCode 0
        exc(32'h01, 32'h80004000, 1'b0, 32'hBFC00380, "int");
        chk("int_cause", cause, 32'h00000300);
        chk("int_epc", epc, 32'h80004000);
        exc(32'h0e, 32'h0, 1'b0, 32'h80004000, "eret3");

        // 5. timer: Count moved clear of 10 before Compare is armed
        mtc0(5'd9, 32'h00000100);
        mtc0(5'd11, 32'd10);
        rd(5'd11, 32'd10, "cmp_rd");
        mtc0(5'd9, 32'd0);
        n = 0;
        while (!tint && n < 40) begin
            cyc();
            n++;
        end
        chk("tmr_latency", 32'(n), 32'd21);
        rd(5'd9, 32'd10, "tmr_count");
        cyc();
        chk("tmr_ip7", 32'(cause[15]), 32'd1);
        mtc0(5'd11, 32'h00001000);
        chk("tmr_clr", 32'(tint), 32'd0);
        cyc();
        chk("tmr_ip7_clr", 32'(cause[15]), 32'd0);
        mtc0(5'd9, 32'h00001000);
        chk("cntwr_nomatch", 32'(tint), 32'd0);
        cyc();
        chk("cntwr_match", 32'(tint), 32'd1);
        mtc0(5'd11, 32'h0);
        chk("cmp0_clr", 32'(tint), 32'd0);

        // 6. Count wrap; Compare=0 never matches
        mtc0(5'd9, 32'hFFFFFFFF);
        rd(5'd9, 32'hFFFFFFFF, "wrap_pre");
        cyc();
        cyc();
        rd(5'd9, 32'h0, "wrap_post");
        chk("wrap_tint", 32'(tint), 32'd0);
        int_l = 6'b000001;
        cyc();
        chk("hwint_ip", 32'(cause[15:8]), 32'h07);
        int_l = 6'b100000;
        cyc();
        chk("hwint5_ip", 32'(cause[15:8]), 32'h83);
        int_l = '0;
        rd(5'd3, 32'h0, "unimpl_rd");

        // asynchronous reset mid-run; flush still follows excepttype
        #2;
        resetn = 1'b0;
        excepttype = 32'h09;
        #1;
        chk("arst_flush", 32'(flush), 32'd1);
        chk("arst_status", status, 32'h00400000);
        chk("arst_epc", epc, 32'h0);
        chk("arst_cause", cause, 32'h0);
        rd(5'd9, 32'h0, "arst_count");
        excepttype = '0;
        cyc();
        resetn = 1'b1;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
